throw_charge_ctl: RTL and testbench



---
 rtl/throw_charge_ctl_pkg.sv | 10 +
 rtl/throw_charge_ctl_btn_sync_edge.sv | 17 +
 rtl/throw_charge_ctl.sv | 95 +++++++++
 tb/tb_throw_charge_ctl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/throw_charge_ctl_pkg.sv
// throw_charge_ctl_pkg: shared types and constants for the throw charge controller
package throw_charge_ctl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CHARGE, ST_THROW, ST_DONE} charge_state_t;
  localparam int FORCE_W = 10;
  localparam int WIND_CALM = 50;
  localparam int WIND_MAX = 100;
  function automatic logic [6:0] wind_map(input logic [6:0] v);
    return (v > 7'(WIND_MAX)) ? v - 7'd27 : v;
  endfunction
endpackage

// File: rtl/throw_charge_ctl_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer for an async button with rise/fall pulses
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[1:0], raw};
  assign level = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/throw_charge_ctl.sv
// throw_charge_ctl: power-bar charge, held throw enable and per-turn wind generation
module throw_charge_ctl
  import throw_charge_ctl_pkg::*;
#(
  parameter int TICK_DIV = 1300000,
  parameter int MAX_FORCE = 1023,
  parameter int STEP = 16,
  parameter int WIND_INIT = WIND_CALM,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic turn_active,
  input  logic btn,
  input  logic throw_done,
  output logic enable,
  output logic [FORCE_W-1:0] throw_force,
  output logic [FORCE_W-1:0] charge_level,
  output logic charging,
  output logic [6:0] wind_force,
  output logic turn_done
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic tick, btn_level, rise, fall, dir_dn, up_sat, dn_zero;
  logic [15:0] lfsr;
  logic [10:0] up_sum;
  logic [FORCE_W-1:0] nxt_level;
  charge_state_t state;
  btn_sync_edge u_sync (.clk(clk), .rst(rst), .raw(btn), .level(btn_level), .rise(rise), .fall(fall));
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // 11-bit compare so the upward step cannot wrap past MAX_FORCE
  always_comb begin
    up_sum = {1'b0, charge_level} + 11'(STEP);
    up_sat = up_sum >= 11'(MAX_FORCE);
    dn_zero = {1'b0, charge_level} <= 11'(STEP);
    nxt_level = dir_dn ? (dn_zero ? '0 : charge_level - FORCE_W'(STEP))
                       : (up_sat ? FORCE_W'(MAX_FORCE) : up_sum[FORCE_W-1:0]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      enable <= 1'b0;
      throw_force <= '0;
      charge_level <= '0;
      charging <= 1'b0;
      wind_force <= 7'(WIND_INIT);
      turn_done <= 1'b0;
      dir_dn <= 1'b0;
    end else begin
      turn_done <= 1'b0;
      case (state)
        ST_IDLE:
          if (rise && turn_active) begin
            charge_level <= '0;
            dir_dn <= 1'b0;
            charging <= 1'b1;
            state <= ST_CHARGE;
          end
        ST_CHARGE:
          if (!turn_active) begin
            charge_level <= '0;
            charging <= 1'b0;
            state <= ST_IDLE;
          end else if (fall) begin
            throw_force <= charge_level;
            enable <= 1'b1;
            charging <= 1'b0;
            state <= ST_THROW;
          end else if (tick) begin
            charge_level <= nxt_level;
            dir_dn <= dir_dn ? !dn_zero : up_sat;
          end
        ST_THROW:
          if (throw_done) begin
            enable <= 1'b0;
            turn_done <= 1'b1;
            wind_force <= wind_map(lfsr[6:0]);
            state <= ST_DONE;
          end
        ST_DONE:
          // hold off re-arming until the throw controller leaves its end state
          if (!throw_done) begin
            charge_level <= '0;
            state <= ST_IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_throw_charge_ctl.sv
// tb_throw_charge_ctl: table-driven charge/throw vectors with a force scoreboard
module tb_throw_charge_ctl;
  import throw_charge_ctl_pkg::*;
  logic clk = 0, rst = 1, turn_active = 0, btn = 0, throw_done = 0;
  logic enable, charging, turn_done;
  logic [9:0] throw_force, charge_level;
  logic [6:0] wind_force;
  logic [15:0] lfsr_m;
  logic prev_en = 0;
  int n_chk = 0, n_fail = 0, pe = 0;
  int q[$];
  typedef struct {bit ta; int n; int force_q;} vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  throw_charge_ctl #(.TICK_DIV(4), .MAX_FORCE(1023), .STEP(16), .WIND_INIT(50), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .turn_active(turn_active), .btn(btn), .throw_done(throw_done),
    .enable(enable), .throw_force(throw_force), .charge_level(charge_level), .charging(charging),
    .wind_force(wind_force), .turn_done(turn_done));
  always @(posedge clk or posedge rst)
    if (rst) begin
      pe <= 0;
      lfsr_m <= 16'hACE1;
    end else begin
      pe <= pe + 1;
      lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
    end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (enable && !prev_en) begin
      if (q.size() == 0) chk("unexpected_enable", 1, 0);
      else chk("throw_force", throw_force, q.pop_front());
    end
    prev_en = enable;
  end
  task automatic throw_cycle();
    logic [6:0] v;
    int w;
    v = lfsr_m[6:0];
    w = v > 100 ? v - 27 : v;
    throw_done = 1;
    @(negedge clk);
    chk("en_drop", enable, 0);
    chk("turn_done_hi", turn_done, 1);
    chk("wind", wind_force, w);
    chk("wind_range", int'(wind_force <= 7'd100), 1);
    @(negedge clk);
    chk("turn_done_pulse", turn_done, 0);
    repeat (3) @(negedge clk);
    chk("hold_done", dut.state, ST_DONE);
    throw_done = 0;
    @(negedge clk);
    chk("back_idle", dut.state, ST_IDLE);
    chk("lvl_clear", charge_level, 0);
  endtask
  task automatic align();
    while (pe % 4 != 0) @(negedge clk);
  endtask
  task automatic charge(input bit ta, input int n, input int f);
    align();
    turn_active = ta;
    btn = 1;
    repeat (4 * n) @(negedge clk);
    btn = 0;
    if (ta) q.push_back(f);
    repeat (2) @(negedge clk);
    chk("pre_en", enable, 0);
    chk("charging_hold", charging, int'(ta));
    @(negedge clk);
    chk("en_rise", enable, int'(ta));
    chk("charging_drop", charging, 0);
    if (ta) throw_cycle();
    else turn_active = 1;
  endtask
  initial begin
    tbl[0] = '{1, 10, 160};
    tbl[1] = '{1, 70, 927};
    tbl[2] = '{1, 1, 16};
    tbl[3] = '{1, 64, 1023};
    tbl[4] = '{1, 65, 1007};
    tbl[5] = '{0, 5, 0};
    tbl[6] = '{1, 127, 15};
    tbl[7] = '{1, 128, 0};
    tbl[8] = '{1, 130, 32};
    repeat (3) @(negedge clk);
    chk("rst_enable", enable, 0);
    chk("rst_force", throw_force, 0);
    chk("rst_level", charge_level, 0);
    chk("rst_charging", charging, 0);
    chk("rst_wind", wind_force, 50);
    chk("rst_turn_done", turn_done, 0);
    rst = 0;
    turn_active = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) charge(tbl[i].ta, tbl[i].n, tbl[i].force_q);
    align();
    btn = 1;
    repeat (20) @(negedge clk);
    chk("abort_charging", charging, 1);
    chk("abort_lvl_nz", int'(charge_level != 0), 1);
    turn_active = 0;
    @(negedge clk);
    chk("abort_idle", charging, 0);
    chk("abort_lvl", charge_level, 0);
    chk("abort_en", enable, 0);
    btn = 0;
    repeat (4) @(negedge clk);
    chk("abort_no_en", enable, 0);
    turn_active = 1;
    align();
    btn = 1;
    repeat (12) @(negedge clk);
    btn = 0;
    q.push_back(48);
    repeat (3) @(negedge clk);
    chk("held_en", enable, 1);
    btn = 1;
    repeat (6) @(negedge clk);
    chk("held_throw_en", enable, 1);
    chk("held_throw_force", throw_force, 48);
    throw_cycle();
    repeat (8) @(negedge clk);
    chk("held_no_charge", charging, 0);
    chk("held_idle", dut.state, ST_IDLE);
    btn = 0;
    repeat (4) @(negedge clk);
    align();
    btn = 1;
    repeat (3) @(negedge clk);
    chk("repress_charging", charging, 1);
    repeat (5) @(negedge clk);
    btn = 0;
    q.push_back(32);
    repeat (3) @(negedge clk);
    chk("repress_en", enable, 1);
    #2 rst = 1;
    #1;
    chk("arst_enable", enable, 0);
    chk("arst_force", throw_force, 0);
    chk("arst_wind", wind_force, 50);
    chk("arst_charging", charging, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
